// File: rtl/enemy_pkg.sv
// Shared definitions for the enemy subsystem: slot limits, id width and
// the hit-report FSM state encoding.
package enemy_pkg;

    localparam int unsigned MAX_ENEMIES = 16;
    localparam int unsigned ID_WIDTH    = 4;

    typedef enum logic {
        StIdle,
        StReport
    } reportState_t;

endpackage

// File: rtl/enemy_lowestBitFinder.sv
// Combinational priority encoder: index of the lowest set bit of vec, plus a
// found flag that is low when vec is all zeros.
module enemy_lowestBitFinder
    import enemy_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0]    vec,
    output logic [ID_WIDTH-1:0] lowestIdx,
    output logic                found
);

    // Scan downwards so the lowest set bit is the last (winning) assignment.
    always_comb begin
        lowestIdx = '0;
        found     = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowestIdx = ID_WIDTH'(i);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/enemy_collision_dispatcher.sv
// Per-pixel collision dispatcher: latches enemy border/shot contacts, replays
// direction changes in the next frame, reports kills one per cycle and flags
// player contact once per frame.
module enemy_collision_dispatcher
    import enemy_pkg::*;
#(
    parameter int unsigned AMOUNT_OF_ENEMIES = 2,
    parameter int unsigned KILL_COUNT_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic                        enemyDrawReq,
    input  logic                        headsUpDrawReq,
    input  logic [3:0]                  drawingRequestorId,
    input  logic                        borderDrawReq,
    input  logic                        shotDrawReq,
    input  logic                        playerDrawReq,
    output logic                        changeDir,
    output logic                        hitValid,
    output logic [3:0]                  hitId,
    output logic                        playerHit,
    output logic [KILL_COUNT_WIDTH-1:0] killCount,
    output logic                        allDead
);

    localparam int unsigned N =
        (AMOUNT_OF_ENEMIES > MAX_ENEMIES) ? MAX_ENEMIES : AMOUNT_OF_ENEMIES;

    logic [N-1:0] aliveQ, aliveD;
    logic [N-1:0] dirPendingQ, dirPendingD;
    logic [N-1:0] dirActiveQ, dirActiveD;
    logic [N-1:0] hitPendingQ, hitPendingD;
    logic [N-1:0] hitReportQ, hitReportD;
    logic [KILL_COUNT_WIDTH-1:0] killCountQ, killCountD;
    logic                        hitValidQ, hitValidD;
    logic [ID_WIDTH-1:0]         hitIdQ, hitIdD;
    logic                        playerHitQ, playerHitD;
    logic                        playerLatchQ, playerLatchD;
    reportState_t                stateQ, stateD;

    logic [N-1:0]        idMask;
    logic [N-1:0]        liveMask;
    logic [N-1:0]        dirSet;
    logic [N-1:0]        hitSet;
    logic [N-1:0]        changeMask;
    logic [N-1:0]        killMask;
    logic [N-1:0]        remaining;
    logic [ID_WIDTH-1:0] lowestIdx;
    logic                found;
    logic                emit;
    logic                playerContact;

    // One-hot decode of the drawing id; ids outside the slot range decode to zero.
    always_comb begin
        idMask = '0;
        for (int i = 0; i < int'(N); i++) begin
            idMask[i] = (drawingRequestorId == ID_WIDTH'(i));
        end
    end

    assign liveMask      = idMask & aliveQ;
    assign dirSet        = (enemyDrawReq && borderDrawReq) ? liveMask : '0;
    assign hitSet        = (enemyDrawReq && shotDrawReq) ? liveMask : '0;
    assign changeMask    = enemyDrawReq ? (liveMask & dirActiveQ) : '0;
    assign playerContact = playerDrawReq && (enemyDrawReq || headsUpDrawReq);

    enemy_lowestBitFinder #(
        .WIDTH(N)
    ) u_lowestBitFinder (
        .vec      (hitReportQ),
        .lowestIdx(lowestIdx),
        .found    (found)
    );

    assign emit = (stateQ == StReport) && found;

    always_comb begin
        killMask = '0;
        for (int i = 0; i < int'(N); i++) begin
            killMask[i] = emit && (lowestIdx == ID_WIDTH'(i));
        end
    end

    always_comb begin
        aliveD       = aliveQ;
        hitReportD   = hitReportQ;
        killCountD   = killCountQ;
        hitValidD    = 1'b0;
        hitIdD       = hitIdQ;
        stateD       = stateQ;
        remaining    = '0;
        hitPendingD  = hitPendingQ | hitSet;
        dirPendingD  = startOfFrame ? dirSet : (dirPendingQ | dirSet);
        dirActiveD   = startOfFrame ? dirPendingQ : (dirActiveQ & ~changeMask);
        playerHitD   = playerContact && (startOfFrame || !playerLatchQ);
        playerLatchD = startOfFrame ? playerContact : (playerLatchQ | playerContact);

        unique case (stateQ)
            StIdle: begin
                if (startOfFrame) begin
                    hitReportD  = hitPendingQ;
                    hitPendingD = hitSet;
                    if (hitPendingQ != '0) begin
                        stateD = StReport;
                    end
                end
            end
            StReport: begin
                remaining = hitReportQ & ~killMask;
                if (emit) begin
                    hitValidD = 1'b1;
                    hitIdD    = lowestIdx;
                    aliveD    = aliveQ & ~killMask;
                    if (killCountQ != '1) begin
                        killCountD = killCountQ + KILL_COUNT_WIDTH'(1);
                    end
                end
                if (startOfFrame) begin
                    remaining   = remaining | hitPendingQ;
                    hitPendingD = hitSet;
                end
                hitReportD = remaining;
                stateD     = (remaining != '0) ? StReport : StIdle;
            end
            default: stateD = StIdle;
        endcase

        // A kill retires any contact still queued for that enemy.
        hitPendingD = hitPendingD & ~killMask;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            aliveQ       <= '1;
            dirPendingQ  <= '0;
            dirActiveQ   <= '0;
            hitPendingQ  <= '0;
            hitReportQ   <= '0;
            killCountQ   <= '0;
            hitValidQ    <= 1'b0;
            hitIdQ       <= '0;
            playerHitQ   <= 1'b0;
            playerLatchQ <= 1'b0;
            stateQ       <= StIdle;
        end else begin
            aliveQ       <= aliveD;
            dirPendingQ  <= dirPendingD;
            dirActiveQ   <= dirActiveD;
            hitPendingQ  <= hitPendingD;
            hitReportQ   <= hitReportD;
            killCountQ   <= killCountD;
            hitValidQ    <= hitValidD;
            hitIdQ       <= hitIdD;
            playerHitQ   <= playerHitD;
            playerLatchQ <= playerLatchD;
            stateQ       <= stateD;
        end
    end

    assign changeDir = |changeMask;
    assign hitValid  = hitValidQ;
    assign hitId     = hitIdQ;
    assign playerHit = playerHitQ;
    assign killCount = killCountQ;
    assign allDead   = (aliveQ == '0);

endmodule

// File: doc/enemy_collision_dispatcher.md
ENEMY_COLLISION_DISPATCHER -- requirements
Module: enemy_collision_dispatcher

Interface
REQ-001 SHALL have parameter AMOUNT_OF_ENEMIES, default 2, range 1..16: number of enemy slots.
REQ-002 SHALL have parameter KILL_COUNT_WIDTH, default 8: kill counter width.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetN  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port startOfFrame  input  1  one-cycle frame-start strobe.
REQ-006 SHALL have port enemyDrawReq  input  1  an enemy body is drawing the current pixel.
REQ-007 SHALL have port headsUpDrawReq  input  1  an enemy heads-up zone is drawing the current pixel.
REQ-008 SHALL have port drawingRequestorId  input  4  index of the enemy currently drawing.
REQ-009 SHALL have port borderDrawReq  input  1  border is drawing the current pixel.
REQ-010 SHALL have port shotDrawReq  input  1  player shot is drawing the current pixel.
REQ-011 SHALL have port playerDrawReq  input  1  player is drawing the current pixel.
REQ-012 SHALL have port changeDir  output  1  direction-change request, sent back to the enemy stock manager.
REQ-013 SHALL have port hitValid  output  1  one-cycle hit-report strobe.
REQ-014 SHALL have port hitId  output  4  enemy index qualified by hitValid.
REQ-015 SHALL have port playerHit  output  1  one-cycle player-contact strobe.
REQ-016 SHALL have port killCount  output  KILL_COUNT_WIDTH  number of enemies killed.
REQ-017 SHALL have port allDead  output  1  high when no enemy is alive.

Function
REQ-018 SHALL treat any drawingRequestorId >= AMOUNT_OF_ENEMIES as invalid and ignore every event carrying it.
REQ-019 SHALL set dirPending[id] on a cycle where enemyDrawReq, borderDrawReq and alive[id] are all high.
REQ-020 On startOfFrame, SHALL load dirActive from dirPending; dirPending SHALL reload only with the event from that same cycle, if any.
REQ-021 SHALL drive changeDir combinationally as enemyDrawReq && valid id && dirActive[id] && alive[id].
REQ-022 SHALL clear dirActive[id] on the cycle after changeDir asserts, so changeDir asserts in exactly one cycle per flagged enemy per frame.
REQ-023 SHALL set hitPending[id] on a cycle where enemyDrawReq, shotDrawReq and alive[id] are all high.
REQ-024 SHALL implement a report FSM with two states: IDLE and REPORT.
REQ-025 In IDLE, on startOfFrame, SHALL copy hitPending into hitReport, clear hitPending and go to REPORT if hitReport is non-zero; otherwise SHALL stay in IDLE.
REQ-026 In REPORT, on each cycle, SHALL register the lowest set bit of hitReport as hitId with hitValid=1, clear that bit and alive[id], and increment killCount, saturating at all-ones.
REQ-027 SHALL return from REPORT to IDLE on the cycle the last hitReport bit is emitted.
REQ-028 If startOfFrame occurs while in REPORT, SHALL OR hitPending into hitReport and stay in REPORT.
REQ-029 SHALL treat border and shot events on the same enemy in the same cycle independently, setting both pending bits.
REQ-030 SHALL assert playerHit for one cycle on the first cycle per frame where playerDrawReq && (enemyDrawReq || headsUpDrawReq); a latch cleared by startOfFrame SHALL suppress repeats within that frame.
REQ-031 SHALL ignore all events for dead enemies, and changeDir SHALL stay low for them.
REQ-032 SHALL drive allDead combinationally as alive == 0.

Reset
REQ-033 When resetN is low at a clock edge, SHALL set: alive all-ones for the lowest AMOUNT_OF_ENEMIES bits; dirPending, dirActive, hitPending, hitReport, killCount, hitValid, hitId, playerHit and the player latch to 0; FSM to IDLE.
REQ-034 A reset during REPORT SHALL drop all unreported hits and emit no further hitValid.

Structure
REQ-035 SHALL take the FSM state enum and MAX_ENEMIES=16 from a shared package, enemy_pkg.
REQ-036 SHALL contain one sub-module, enemy_lowestBitFinder: a parameterised combinational priority encoder returning the lowest set index and a found flag.

Verification
REQ-037 N=2; border contact on id 1 in frame 0 -> changeDir high for exactly one cycle at id 1's first drawn pixel in frame 1, and none in frame 2.
REQ-038 Shots hit ids 0 and 1 in frame 0 -> after the frame-1 startOfFrame, hitValid on 2 consecutive cycles with hitId 0 then 1; killCount=2; allDead=1.
REQ-039 Border event with drawingRequestorId=5, N=2 -> no state change; changeDir stays 0.
REQ-040 KILL_COUNT_WIDTH=2 with 5 kills -> killCount saturates at 3.
REQ-041 Player overlaps heads-up zone for 40 cycles in one frame -> exactly one playerHit pulse; a second pulse occurs in the next frame if overlap continues.
REQ-042 resetN low on the cycle after the first hitValid of a 2-hit report -> no second hitValid, killCount=0, alive restored.
